// File: rtl/spi_ram_responder.sv
// SPI-attached byte RAM: 0x03 read / 0x02 write with 24-bit address and auto-increment bursts.
// Latency: spi_miso updates on the active edge; wr_strobe follows the committing edge by one cycle.
// Backpressure: none; the initiator paces bits with spi_clk_en and gaps freeze all state.
module spi_ram_responder #(
    parameter int MEM_BYTES = 1024,
    parameter int AW        = 10
) (
    input  logic          cpu_clk,
    input  logic          rstn,
    input  logic          spi_select,
    input  logic          spi_clk_en,
    input  logic          spi_mosi,
    output logic          spi_miso,
    output logic          wr_strobe,
    output logic [AW-1:0] wr_addr,
    output logic          busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_READ, S_WRITE, S_IGNORE
    } state_t;

    state_t        state, state_nxt;
    logic [7:0]    mem [MEM_BYTES];
    logic [4:0]    bit_cnt;
    logic [6:0]    cmd_sr;
    logic [6:0]    byte_sr;
    logic [AW-1:0] addr;
    logic          op_write;
    logic          armed;

    logic [7:0]    cmd_full;
    logic [7:0]    wr_data;
    logic [AW-1:0] addr_next;
    logic [AW-1:0] addr_inc;
    logic          last_bit8;
    logic          last_bit24;
    logic          mem_we;

    assign cmd_full   = {cmd_sr, spi_mosi};
    assign wr_data    = {byte_sr, spi_mosi};
    assign addr_next  = {addr[AW-2:0], spi_mosi};
    assign addr_inc   = addr + AW'(1);
    assign last_bit8  = (bit_cnt == 5'd7);
    assign last_bit24 = (bit_cnt == 5'd23);
    // Deselect and reset both veto the commit, so a torn byte never lands.
    assign mem_we     = rstn && !spi_select && spi_clk_en && (state == S_WRITE) && last_bit8;

    always_ff @(posedge cpu_clk) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (spi_select) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (armed) state_nxt = S_CMD;
                S_CMD:   if (spi_clk_en && last_bit8)
                             state_nxt = (cmd_full == 8'h03 || cmd_full == 8'h02) ? S_ADDR : S_IGNORE;
                S_ADDR:  if (spi_clk_en && last_bit24)
                             state_nxt = op_write ? S_WRITE : S_READ;
                default: ;
            endcase
        end
    end

    always_comb begin
        busy = (state != S_IDLE);
    end

    // A transaction may only begin after select has been seen high since reset.
    always_ff @(posedge cpu_clk) begin
        if (!rstn)           armed <= 1'b0;
        else if (spi_select) armed <= 1'b1;
    end

    always_ff @(posedge cpu_clk) begin
        if (mem_we) mem[addr] <= wr_data;
    end

    always_ff @(posedge cpu_clk) begin
        if (!rstn) begin
            bit_cnt   <= '0;
            cmd_sr    <= '0;
            byte_sr   <= '0;
            addr      <= '0;
            op_write  <= 1'b0;
            spi_miso  <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
        end else begin
            wr_strobe <= 1'b0;
            if (spi_select) begin
                bit_cnt  <= '0;
                cmd_sr   <= '0;
                byte_sr  <= '0;
                op_write <= 1'b0;
                spi_miso <= 1'b0;
            end else if (spi_clk_en) begin
                case (state)
                    S_IDLE: if (armed) begin
                        cmd_sr  <= {cmd_sr[5:0], spi_mosi};
                        bit_cnt <= 5'd1;
                    end
                    S_CMD: begin
                        cmd_sr <= {cmd_sr[5:0], spi_mosi};
                        if (last_bit8) begin
                            bit_cnt  <= '0;
                            op_write <= (cmd_full == 8'h02);
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                    S_ADDR: begin
                        addr <= addr_next;
                        if (last_bit24) begin
                            bit_cnt <= '0;
                            if (!op_write) begin
                                byte_sr  <= mem[addr_next][6:0];
                                spi_miso <= mem[addr_next][7];
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                    S_READ: begin
                        if (last_bit8) begin
                            bit_cnt  <= '0;
                            addr     <= addr_inc;
                            byte_sr  <= mem[addr_inc][6:0];
                            spi_miso <= mem[addr_inc][7];
                        end else begin
                            bit_cnt  <= bit_cnt + 5'd1;
                            byte_sr  <= {byte_sr[5:0], 1'b0};
                            spi_miso <= byte_sr[6];
                        end
                    end
                    S_WRITE: begin
                        byte_sr <= {byte_sr[5:0], spi_mosi};
                        if (last_bit8) begin
                            bit_cnt   <= '0;
                            addr      <= addr_inc;
                            wr_strobe <= 1'b1;
                            wr_addr   <= addr;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_ram_responder.sv
// Randomised bench for spi_ram_responder: stimulus pushes expected write addresses and read
// bytes from a byte-array model; an independent negedge monitor pops and compares.
module tb_spi_ram_responder;
    localparam int MEM_BYTES = 1024;
    localparam int AW        = 10;

    logic          cpu_clk    = 1'b0;
    logic          rstn       = 1'b0;
    logic          spi_select = 1'b0;
    logic          spi_clk_en = 1'b0;
    logic          spi_mosi   = 1'b0;
    logic          spi_miso;
    logic          wr_strobe;
    logic [AW-1:0] wr_addr;
    logic          busy;

    always #5 cpu_clk = ~cpu_clk;

    spi_ram_responder #(.MEM_BYTES(MEM_BYTES), .AW(AW)) dut (
        .cpu_clk    (cpu_clk),
        .rstn       (rstn),
        .spi_select (spi_select),
        .spi_clk_en (spi_clk_en),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .wr_strobe  (wr_strobe),
        .wr_addr    (wr_addr),
        .busy       (busy)
    );

    int           n_cmp = 0;
    int           n_bad = 0;
    byte unsigned mdl [MEM_BYTES];
    int unsigned  exp_wr_q [$];
    byte unsigned exp_rd_q [$];
    byte unsigned wbuf [$];
    bit           rd_phase = 1'b0;
    bit           mon_en   = 1'b0;
    int           gap_pct  = 0;

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        while (int'($urandom_range(99)) < gap_pct) begin
            spi_clk_en = 1'b0;
            spi_mosi   = 1'($urandom);
            tick();
        end
        spi_clk_en = 1'b1;
        spi_mosi   = b;
        tick();
        spi_clk_en = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a24);
        spi_select = 1'b0;
        send_byte(cmd);
        for (int i = 23; i >= 0; i--) send_bit(a24[i]);
    endtask

    task automatic deselect();
        spi_select = 1'b1;
        spi_clk_en = 1'($urandom);
        tick();
        rd_phase = 1'b0;
        repeat ($urandom_range(2)) tick();
    endtask

    task automatic write_txn(input logic [23:0] a24);
        int unsigned a;
        a = a24 % MEM_BYTES;
        send_hdr(8'h02, a24);
        foreach (wbuf[k]) begin
            mdl[a] = wbuf[k];
            exp_wr_q.push_back(a);
            send_byte(wbuf[k]);
            a = (a + 1) % MEM_BYTES;
        end
        deselect();
    endtask

    task automatic read_txn(input logic [23:0] a24, input int n);
        int unsigned a;
        a = a24 % MEM_BYTES;
        send_hdr(8'h03, a24);
        rd_phase = 1'b1;
        for (int k = 0; k < n; k++) begin
            exp_rd_q.push_back(mdl[a]);
            a = (a + 1) % MEM_BYTES;
            send_byte(8'($urandom));
        end
        deselect();
    endtask

    task automatic unknown_txn(input logic [7:0] cmd, input int nbits);
        spi_select = 1'b0;
        send_byte(cmd);
        check("ignore_busy_cmd", busy, 1);
        for (int i = 0; i < nbits; i++) begin
            send_bit(1'($urandom));
            check("ignore_busy", busy, 1);
        end
        deselect();
        check("ignore_busy_after", busy, 0);
    endtask

    initial begin
        logic [7:0] sh;
        int         nb;
        bit         prev_gap;
        logic       prev_miso;
        bit         act;
        sh = '0; nb = 0; prev_gap = 1'b0; prev_miso = 1'b0;
        forever begin
            @(negedge cpu_clk);
            if (mon_en) begin
                if (wr_strobe === 1'b1) begin
                    if (exp_wr_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL spurious_wr_strobe: got strobe at wr_addr 0x%0h, expected none", wr_addr);
                    end else begin
                        check("wr_addr", wr_addr, exp_wr_q.pop_front());
                    end
                end
                act = !spi_select && spi_clk_en;
                if (rd_phase) begin
                    if (prev_gap) check("miso_gap_hold", spi_miso, prev_miso);
                    if (act) begin
                        sh = {sh[6:0], spi_miso};
                        nb++;
                        if (nb == 8) begin
                            nb = 0;
                            if (exp_rd_q.size() == 0) begin
                                n_cmp++; n_bad++;
                                $display("FAIL spurious_rd_byte: got 0x%0h, expected no byte", sh);
                            end else begin
                                check("rd_byte", sh, exp_rd_q.pop_front());
                            end
                        end
                    end
                    prev_gap  = !act;
                    prev_miso = spi_miso;
                end else begin
                    nb       = 0;
                    prev_gap = 1'b0;
                    check("miso_idle_zero", spi_miso, 0);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no completion, expected finish within time limit");
        $fatal(1);
    end

    initial begin
        int          kind;
        int          n;
        logic [23:0] a;
        logic [7:0]  cmd;

        // Reset with select held low: block must stay idle until select is seen high.
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_miso", spi_miso, 0);
        check("rst_wr_strobe", wr_strobe, 0);
        check("rst_wr_addr", wr_addr, 0);
        rstn   = 1'b1;
        mon_en = 1'b1;
        send_byte(8'h02);
        for (int i = 0; i < 12; i++) send_bit(1'($urandom));
        check("no_start_without_reselect", busy, 0);
        deselect();

        // Fill the whole array; upper address bits must be discarded.
        wbuf.delete();
        for (int i = 0; i < MEM_BYTES; i++) wbuf.push_back(8'($urandom));
        write_txn(24'hAB0000);

        wbuf = {8'hA5, 8'h3C};
        write_txn(24'h000010);
        read_txn(24'h000010, 2);

        wbuf = {8'hFF, 8'h11};
        write_txn(24'h0003FF);
        read_txn(24'h000000, 1);
        read_txn(24'h0403FF, 1);

        read_txn(24'h000010, 4);
        gap_pct = 60;
        read_txn(24'h000010, 4);
        gap_pct = 0;

        // Partial write byte then deselect.
        send_hdr(8'h02, 24'h000020);
        for (int i = 0; i < 5; i++) send_bit(1'($urandom));
        deselect();
        read_txn(24'h000020, 1);

        // Deselect coinciding with the 8th data bit wins.
        send_hdr(8'h02, 24'h000021);
        for (int i = 0; i < 7; i++) send_bit(1'($urandom));
        spi_select = 1'b1;
        spi_clk_en = 1'b1;
        spi_mosi   = 1'b1;
        tick();
        spi_clk_en = 1'b0;
        tick();
        read_txn(24'h000021, 1);

        unknown_txn(8'h9F, 40);

        // Reset on the 3rd read data bit.
        send_hdr(8'h03, 24'h000010);
        rd_phase = 1'b1;
        send_bit(1'b0);
        send_bit(1'b0);
        rstn       = 1'b0;
        spi_clk_en = 1'b1;
        tick();
        check("midrd_rst_miso", spi_miso, 0);
        check("midrd_rst_busy", busy, 0);
        check("midrd_rst_wr_addr", wr_addr, 0);
        rd_phase   = 1'b0;
        spi_clk_en = 1'b0;
        rstn       = 1'b1;
        spi_select = 1'b1;
        tick();
        read_txn(24'h000010, 2);

        for (int t = 0; t < 40; t++) begin
            kind    = $urandom_range(2);
            n       = $urandom_range(1, 4);
            a       = 24'($urandom);
            gap_pct = $urandom_range(50);
            case (kind)
                0: begin
                    wbuf.delete();
                    repeat (n) wbuf.push_back(8'($urandom));
                    write_txn(a);
                end
                1: read_txn(a, n);
                default: begin
                    cmd = 8'($urandom);
                    while (cmd == 8'h02 || cmd == 8'h03) cmd = 8'($urandom);
                    unknown_txn(cmd, $urandom_range(40));
                end
            endcase
        end
        gap_pct = 0;

        repeat (3) tick();
        check("wr_queue_drained", exp_wr_q.size(), 0);
        check("rd_queue_drained", exp_rd_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
